// File: rtl/adma_pkg.sv
// Shared constants and descriptor type for the ADMA transaction scheduler
// and the channel controllers that feed it.
package adma_pkg;

  localparam int SRC_ERR_BIT = 0;
  localparam int DST_ERR_BIT = 1;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  // Default-width descriptor view used by channel controllers.
  localparam int DESC_ADDR_W = 32;
  localparam int DESC_LEN_W  = 8;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] araddr;
    logic [DESC_LEN_W-1:0]  arlen;
    logic [1:0]             arburst;
    logic [DESC_ADDR_W-1:0] awaddr;
    logic [DESC_LEN_W-1:0]  awlen;
    logic [1:0]             awburst;
  } adma_desc_t;

endpackage

// File: rtl/adma_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from a registered
// pointer, which moves to one past the winner whenever adv is asserted.
module adma_rr_arbiter
  import adma_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             adv,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    gnt     = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[wrap_add(ptr, i)]) begin
        found   = 1'b1;
        gnt_idx = wrap_add(ptr, i);
      end
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = found && (gnt_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= wrap_add(gnt_idx, 1);
    end
  end

endmodule

// File: rtl/adma_atx_scheduler.sv
// Arbitrates per-channel DMA descriptors onto the data mover's single atx port
// and tracks per-channel outstanding transactions and completion status.
module adma_atx_scheduler
  import adma_pkg::*;
#(
  parameter int DMA_CHN_NUM  = 4,
  parameter int MST_ID_W     = 5,
  parameter int SRC_ADDR_W   = 32,
  parameter int DST_ADDR_W   = 32,
  parameter int ATX_LEN_W    = 8,
  parameter int CHN_OSTD_MAX = 2,
  localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sched_en,
  input  logic [DMA_CHN_NUM-1:0]          chn_req_vld,
  output logic [DMA_CHN_NUM-1:0]          chn_req_rdy,
  input  logic [DMA_CHN_NUM*SRC_ADDR_W-1:0] chn_araddr,
  input  logic [DMA_CHN_NUM*ATX_LEN_W-1:0]  chn_arlen,
  input  logic [DMA_CHN_NUM*2-1:0]        chn_arburst,
  input  logic [DMA_CHN_NUM*DST_ADDR_W-1:0] chn_awaddr,
  input  logic [DMA_CHN_NUM*ATX_LEN_W-1:0]  chn_awlen,
  input  logic [DMA_CHN_NUM*2-1:0]        chn_awburst,
  output logic [DMA_CHN_NUM-1:0]          chn_cpl_vld,
  output logic [DMA_CHN_NUM*2-1:0]        chn_cpl_err,
  output logic [DMA_CHN_NUM-1:0]          chn_busy,
  output logic [DMA_CHN_NUM_W-1:0]        atx_chn_id,
  output logic [MST_ID_W-1:0]             atx_arid,
  output logic [MST_ID_W-1:0]             atx_awid,
  output logic [SRC_ADDR_W-1:0]           atx_araddr,
  output logic [ATX_LEN_W-1:0]            atx_arlen,
  output logic [1:0]                      atx_arburst,
  output logic [DST_ADDR_W-1:0]           atx_awaddr,
  output logic [ATX_LEN_W-1:0]            atx_awlen,
  output logic [1:0]                      atx_awburst,
  output logic                            atx_vld,
  input  logic                            atx_rdy,
  output logic [DMA_CHN_NUM*MST_ID_W-1:0] atx_id,
  input  logic [DMA_CHN_NUM-1:0]          atx_done,
  input  logic [DMA_CHN_NUM-1:0]          atx_src_err,
  input  logic [DMA_CHN_NUM-1:0]          atx_dst_err
);

  localparam int OSTD_W = $clog2(CHN_OSTD_MAX + 1);
  localparam logic [OSTD_W-1:0] OSTD_LIMIT = OSTD_W'(CHN_OSTD_MAX);

  logic                     slot_free;
  logic                     grant;
  logic [DMA_CHN_NUM-1:0]   eligible;
  logic [DMA_CHN_NUM-1:0]   arb_req;
  logic [DMA_CHN_NUM-1:0]   gnt;
  logic [DMA_CHN_NUM_W-1:0] gnt_idx;
  logic [DMA_CHN_NUM-1:0]   ostd_inc;
  logic [DMA_CHN_NUM-1:0]   ostd_dec;
  logic [OSTD_W-1:0]        ostd [DMA_CHN_NUM];
  logic [DMA_CHN_NUM-1:0]   src_sticky;
  logic [DMA_CHN_NUM-1:0]   dst_sticky;

  assign slot_free = !atx_vld || atx_rdy;

  // Gated by rst_n so chn_req_rdy reads zero while reset is held.
  always_comb begin
    eligible = '0;
    ostd_inc = '0;
    ostd_dec = '0;
    for (int c = 0; c < DMA_CHN_NUM; c++) begin
      eligible[c] = rst_n && sched_en && chn_req_vld[c] && (ostd[c] < OSTD_LIMIT);
      ostd_inc[c] = gnt[c];
      ostd_dec[c] = atx_done[c] && (ostd[c] != '0);
    end
  end

  assign arb_req     = slot_free ? eligible : '0;
  assign grant       = |gnt;
  assign chn_req_rdy = gnt;

  adma_rr_arbiter #(.N(DMA_CHN_NUM)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .adv     (grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      atx_vld     <= 1'b0;
      atx_chn_id  <= '0;
      atx_araddr  <= '0;
      atx_arlen   <= '0;
      atx_arburst <= '0;
      atx_awaddr  <= '0;
      atx_awlen   <= '0;
      atx_awburst <= '0;
    end else if (slot_free) begin
      atx_vld <= grant;
      if (grant) begin
        atx_chn_id  <= gnt_idx;
        atx_araddr  <= chn_araddr[int'(gnt_idx)*SRC_ADDR_W +: SRC_ADDR_W];
        atx_arlen   <= chn_arlen[int'(gnt_idx)*ATX_LEN_W +: ATX_LEN_W];
        atx_arburst <= chn_arburst[int'(gnt_idx)*2 +: 2];
        atx_awaddr  <= chn_awaddr[int'(gnt_idx)*DST_ADDR_W +: DST_ADDR_W];
        atx_awlen   <= chn_awlen[int'(gnt_idx)*ATX_LEN_W +: ATX_LEN_W];
        atx_awburst <= chn_awburst[int'(gnt_idx)*2 +: 2];
      end
    end
  end

  assign atx_arid = MST_ID_W'(atx_chn_id);
  assign atx_awid = MST_ID_W'(atx_chn_id);

  for (genvar c = 0; c < DMA_CHN_NUM; c++) begin : g_id
    assign atx_id[c*MST_ID_W +: MST_ID_W] = MST_ID_W'(c);
  end

  // Errors arriving with done are reported in that completion and not carried forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < DMA_CHN_NUM; c++) ostd[c] <= '0;
      src_sticky  <= '0;
      dst_sticky  <= '0;
      chn_cpl_vld <= '0;
      chn_cpl_err <= '0;
    end else begin
      chn_cpl_vld <= atx_done;
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
        if (ostd_inc[c] && !ostd_dec[c]) ostd[c] <= ostd[c] + 1'b1;
        else if (ostd_dec[c] && !ostd_inc[c]) ostd[c] <= ostd[c] - 1'b1;
        chn_cpl_err[2*c+SRC_ERR_BIT] <= atx_done[c] && (src_sticky[c] || atx_src_err[c]);
        chn_cpl_err[2*c+DST_ERR_BIT] <= atx_done[c] && (dst_sticky[c] || atx_dst_err[c]);
        src_sticky[c] <= !atx_done[c] && (src_sticky[c] || atx_src_err[c]);
        dst_sticky[c] <= !atx_done[c] && (dst_sticky[c] || atx_dst_err[c]);
      end
    end
  end

  always_comb begin
    chn_busy = '0;
    for (int c = 0; c < DMA_CHN_NUM; c++) begin
      chn_busy[c] = (ostd[c] != '0) || (atx_vld && (atx_chn_id == DMA_CHN_NUM_W'(c)));
    end
  end

endmodule

// File: tb/tb_adma_atx_scheduler.sv
// Directed bench for adma_atx_scheduler: grant latency, round-robin order,
// backpressure, outstanding limit, error reporting, sched_en and async reset.
module tb_adma_atx_scheduler;
  import adma_pkg::*;

  localparam int N = 4, IDW = 5, AW = 32, LW = 8, W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sched_en, atx_rdy, atx_vld;
  logic [N-1:0] chn_req_vld, chn_req_rdy, chn_cpl_vld, chn_busy;
  logic [N-1:0] atx_done, atx_src_err, atx_dst_err;
  logic [N*AW-1:0] chn_araddr, chn_awaddr;
  logic [N*LW-1:0] chn_arlen, chn_awlen;
  logic [N*2-1:0] chn_arburst, chn_awburst, chn_cpl_err;
  logic [W-1:0] atx_chn_id;
  logic [IDW-1:0] atx_arid, atx_awid;
  logic [AW-1:0] atx_araddr, atx_awaddr;
  logic [LW-1:0] atx_arlen, atx_awlen;
  logic [1:0] atx_arburst, atx_awburst;
  logic [N*IDW-1:0] atx_id;

  int checks = 0;
  int errors = 0;

  adma_atx_scheduler dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .chn_req_vld(chn_req_vld), .chn_req_rdy(chn_req_rdy),
    .chn_araddr(chn_araddr), .chn_arlen(chn_arlen), .chn_arburst(chn_arburst),
    .chn_awaddr(chn_awaddr), .chn_awlen(chn_awlen), .chn_awburst(chn_awburst),
    .chn_cpl_vld(chn_cpl_vld), .chn_cpl_err(chn_cpl_err), .chn_busy(chn_busy),
    .atx_chn_id(atx_chn_id), .atx_arid(atx_arid), .atx_awid(atx_awid),
    .atx_araddr(atx_araddr), .atx_arlen(atx_arlen), .atx_arburst(atx_arburst),
    .atx_awaddr(atx_awaddr), .atx_awlen(atx_awlen), .atx_awburst(atx_awburst),
    .atx_vld(atx_vld), .atx_rdy(atx_rdy), .atx_id(atx_id),
    .atx_done(atx_done), .atx_src_err(atx_src_err), .atx_dst_err(atx_dst_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    sched_en = 1'b1; atx_rdy = 1'b1;
    chn_req_vld = '0; atx_done = '0; atx_src_err = '0; atx_dst_err = '0;
    chn_araddr = '0; chn_awaddr = '0; chn_arlen = '0; chn_awlen = '0;
    chn_arburst = '0; chn_awburst = '0;
  endtask

  task automatic do_reset();
    init_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_desc(input int c, input adma_desc_t d);
    chn_araddr[c*AW +: AW] = d.araddr;
    chn_arlen[c*LW +: LW] = d.arlen;
    chn_arburst[c*2 +: 2] = d.arburst;
    chn_awaddr[c*AW +: AW] = d.awaddr;
    chn_awlen[c*LW +: LW] = d.awlen;
    chn_awburst[c*2 +: 2] = d.awburst;
  endtask

  task automatic pulse_grant(input int c);
    chn_req_vld[c] = 1'b1;
    tick();
    chn_req_vld[c] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    init_inputs();
    chn_req_vld = 4'hF;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({atx_vld, chn_req_rdy, chn_busy, chn_cpl_vld, chn_cpl_err} !== 17'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got vld=%b rdy=%b busy=%b cpl=%b err=%b expected all 0",
               atx_vld, chn_req_rdy, chn_busy, chn_cpl_vld, chn_cpl_err);
    end
    checks++;
    if ({atx_chn_id, atx_arid, atx_awid, atx_araddr, atx_awaddr, atx_arlen} !== '0) begin
      errors++;
      $display("FAIL reset_fields: got id=%0d arid=%0d araddr=%h expected 0", atx_chn_id, atx_arid, atx_araddr);
    end
    checks++;
    if (atx_id !== {5'd3, 5'd2, 5'd1, 5'd0}) begin
      errors++;
      $display("FAIL reset_atx_id: got %h expected %h", atx_id, {5'd3, 5'd2, 5'd1, 5'd0});
    end
    @(posedge clk);
    #1;
    chn_req_vld = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_desc(2, '{araddr: 32'h1000, arlen: 8'd7, arburst: INCR, awaddr: 32'h2000, awlen: 8'd7, awburst: INCR});
    chn_req_vld = 4'b0100;
    #1;
    checks++;
    if (chn_req_rdy !== 4'b0100) begin
      errors++; $display("FAIL single_rdy: got %b expected 0100", chn_req_rdy);
    end
    tick();
    chn_req_vld = '0;
    checks++;
    if ({atx_vld, atx_chn_id, atx_arid, atx_awid} !== {1'b1, 2'd2, 5'd2, 5'd2}) begin
      errors++;
      $display("FAIL single_id: got vld=%b chn=%0d arid=%0d awid=%0d expected 1/2/2/2", atx_vld, atx_chn_id, atx_arid, atx_awid);
    end
    checks++;
    if ({atx_araddr, atx_arlen, atx_arburst, atx_awaddr, atx_awlen, atx_awburst} !==
        {32'h1000, 8'd7, INCR, 32'h2000, 8'd7, INCR}) begin
      errors++;
      $display("FAIL single_desc: got ar=%h/%0d/%b aw=%h/%0d/%b expected 1000/7/01 2000/7/01",
               atx_araddr, atx_arlen, atx_arburst, atx_awaddr, atx_awlen, atx_awburst);
    end
    tick();
    checks++;
    if ({atx_vld, chn_busy} !== {1'b0, 4'b0100}) begin
      errors++; $display("FAIL single_inflight: got vld=%b busy=%b expected 0 0100", atx_vld, chn_busy);
    end
    atx_done = 4'b0100;
    tick();
    atx_done = '0;
    checks++;
    if ({chn_cpl_vld, chn_cpl_err, chn_busy} !== {4'b0100, 8'h00, 4'b0000}) begin
      errors++; $display("FAIL single_cpl: got cpl=%b err=%b busy=%b expected 0100 0 0", chn_cpl_vld, chn_cpl_err, chn_busy);
    end
    tick();
    checks++;
    if (chn_cpl_vld !== 4'b0000) begin
      errors++; $display("FAIL single_cpl_pulse: got %b expected 0000", chn_cpl_vld);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] prev, exp_g;
    do_reset();
    for (int c = 0; c < N; c++)
      set_desc(c, '{araddr: 32'h1000 + 32'(c) * 32'h100, arlen: 8'(c), arburst: INCR,
                    awaddr: 32'h8000 + 32'(c) * 32'h100, awlen: 8'(c), awburst: FIXED});
    prev = '0;
    chn_req_vld = 4'hF;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      atx_done = prev;
      #1;
      checks++;
      if (chn_req_rdy !== exp_g) begin
        errors++; $display("FAIL fair_grant[%0d]: got %b expected %b", k, chn_req_rdy, exp_g);
      end
      tick();
      checks++;
      if ({atx_vld, atx_chn_id, atx_araddr, atx_awburst} !== {1'b1, 2'(k % 4), 32'h1000 + 32'(k % 4) * 32'h100, FIXED}) begin
        errors++; $display("FAIL fair_atx[%0d]: got vld=%b chn=%0d araddr=%h expected chn %0d", k, atx_vld, atx_chn_id, atx_araddr, k % 4);
      end
      checks++;
      if (chn_cpl_vld !== prev) begin
        errors++; $display("FAIL fair_cpl[%0d]: got %b expected %b", k, chn_cpl_vld, prev);
      end
      prev = exp_g;
    end
    chn_req_vld = '0;
    atx_done = prev;
    tick();
    atx_done = '0;
    checks++;
    if ({atx_vld, chn_busy, chn_cpl_vld} !== {1'b0, 4'b0000, prev}) begin
      errors++; $display("FAIL fair_drain: got vld=%b busy=%b cpl=%b expected 0 0000 %b", atx_vld, chn_busy, chn_cpl_vld, prev);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_desc(1, '{araddr: 32'hA000, arlen: 8'd3, arburst: INCR, awaddr: 32'hA800, awlen: 8'd5, awburst: INCR});
    set_desc(2, '{araddr: 32'hB000, arlen: 8'd1, arburst: INCR, awaddr: 32'hB800, awlen: 8'd1, awburst: INCR});
    chn_req_vld = 4'b0010;
    #1;
    checks++;
    if (chn_req_rdy !== 4'b0010) begin
      errors++; $display("FAIL bp_first: got %b expected 0010", chn_req_rdy);
    end
    tick();
    chn_req_vld = 4'b1101;
    atx_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({chn_req_rdy, atx_vld, atx_chn_id, atx_araddr, atx_awlen} !== {4'b0000, 1'b1, 2'd1, 32'hA000, 8'd5}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b chn=%0d araddr=%h awlen=%0d expected 0000 1 1 a000 5",
                 i, chn_req_rdy, atx_vld, atx_chn_id, atx_araddr, atx_awlen);
      end
      tick();
    end
    atx_rdy = 1'b1;
    #1;
    checks++;
    if (chn_req_rdy !== 4'b0100) begin
      errors++; $display("FAIL bp_release: got %b expected 0100", chn_req_rdy);
    end
    tick();
    chn_req_vld = '0;
    checks++;
    if ({atx_vld, atx_chn_id, atx_araddr} !== {1'b1, 2'd2, 32'hB000}) begin
      errors++; $display("FAIL bp_next: got vld=%b chn=%0d araddr=%h expected 1 2 b000", atx_vld, atx_chn_id, atx_araddr);
    end
    tick();
    atx_done = 4'b0110;
    tick();
    atx_done = '0;
    checks++;
    if ({chn_cpl_vld, chn_busy, atx_vld} !== {4'b0110, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL bp_cpl: got cpl=%b busy=%b vld=%b expected 0110 0000 0", chn_cpl_vld, chn_busy, atx_vld);
    end
  endtask

  task automatic test_ostd_limit();
    do_reset();
    set_desc(0, '{araddr: 32'hC000, arlen: 8'd15, arburst: INCR, awaddr: 32'hD000, awlen: 8'd15, awburst: INCR});
    chn_req_vld = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (chn_req_rdy !== 4'b0001) begin
        errors++; $display("FAIL ostd_grant[%0d]: got %b expected 0001", i, chn_req_rdy);
      end
      tick();
    end
    #1;
    checks++;
    if (chn_req_rdy !== 4'b0000) begin
      errors++; $display("FAIL ostd_full: got %b expected 0000", chn_req_rdy);
    end
    tick();
    atx_done = 4'b0001;
    #1;
    checks++;
    if (chn_req_rdy !== 4'b0000) begin
      errors++; $display("FAIL ostd_done_cycle: got %b expected 0000", chn_req_rdy);
    end
    tick();
    #1;
    checks++;
    if (chn_req_rdy !== 4'b0001) begin
      errors++; $display("FAIL ostd_third: got %b expected 0001", chn_req_rdy);
    end
    tick();
    atx_done = '0;
    #1;
    checks++;
    if (chn_req_rdy !== 4'b0001) begin
      errors++; $display("FAIL ostd_after_both: got %b expected 0001", chn_req_rdy);
    end
    tick();
    #1;
    checks++;
    if ({chn_req_rdy, chn_busy} !== {4'b0000, 4'b0001}) begin
      errors++; $display("FAIL ostd_full2: got rdy=%b busy=%b expected 0000 0001", chn_req_rdy, chn_busy);
    end
    chn_req_vld = '0;
    atx_done = 4'b0001;
    tick();
    tick();
    atx_done = '0;
    checks++;
    if (chn_busy !== 4'b0000) begin
      errors++; $display("FAIL ostd_drained: got busy=%b expected 0000", chn_busy);
    end
    atx_done = 4'b0001;
    tick();
    atx_done = '0;
    checks++;
    if (chn_busy !== 4'b0000) begin
      errors++; $display("FAIL ostd_spurious_done: got busy=%b expected 0000", chn_busy);
    end
  endtask

  task automatic test_errors();
    do_reset();
    set_desc(3, '{araddr: 32'hE000, arlen: 8'd2, arburst: INCR, awaddr: 32'hF000, awlen: 8'd2, awburst: INCR});
    pulse_grant(3);
    repeat (3) tick();
    atx_src_err = 4'b1000;
    tick();
    atx_src_err = '0;
    repeat (4) tick();
    checks++;
    if (chn_cpl_vld !== 4'b0000) begin
      errors++; $display("FAIL err_no_early_cpl: got %b expected 0000", chn_cpl_vld);
    end
    atx_dst_err = 4'b1000;
    atx_done = 4'b1000;
    tick();
    atx_dst_err = '0;
    atx_done = '0;
    checks++;
    if ({chn_cpl_vld, chn_cpl_err} !== {4'b1000, 8'b1100_0000}) begin
      errors++; $display("FAIL err_both: got cpl=%b err=%b expected 1000 11000000", chn_cpl_vld, chn_cpl_err);
    end
    pulse_grant(3);
    atx_done = 4'b1000;
    tick();
    atx_done = '0;
    checks++;
    if ({chn_cpl_vld, chn_cpl_err} !== {4'b1000, 8'h00}) begin
      errors++; $display("FAIL err_cleared: got cpl=%b err=%b expected 1000 00000000", chn_cpl_vld, chn_cpl_err);
    end
    pulse_grant(3);
    atx_done = 4'b1000;
    atx_src_err = 4'b1000;
    tick();
    atx_done = '0;
    atx_src_err = '0;
    checks++;
    if (chn_cpl_err !== 8'b0100_0000) begin
      errors++; $display("FAIL err_same_cycle: got %b expected 01000000", chn_cpl_err);
    end
    pulse_grant(3);
    atx_done = 4'b1000;
    tick();
    atx_done = '0;
    checks++;
    if (chn_cpl_err !== 8'h00) begin
      errors++; $display("FAIL err_not_carried: got %b expected 00000000", chn_cpl_err);
    end
  endtask

  task automatic test_multi_done();
    do_reset();
    pulse_grant(0);
    pulse_grant(1);
    checks++;
    if (chn_busy !== 4'b0011) begin
      errors++; $display("FAIL multi_busy: got %b expected 0011", chn_busy);
    end
    atx_done = 4'b0011;
    atx_dst_err = 4'b0010;
    tick();
    atx_done = '0;
    atx_dst_err = '0;
    checks++;
    if ({chn_cpl_vld, chn_cpl_err, chn_busy} !== {4'b0011, 8'b0000_1000, 4'b0000}) begin
      errors++; $display("FAIL multi_cpl: got cpl=%b err=%b busy=%b expected 0011 00001000 0000", chn_cpl_vld, chn_cpl_err, chn_busy);
    end
  endtask

  task automatic test_sched_en();
    do_reset();
    set_desc(1, '{araddr: 32'h3000, arlen: 8'd4, arburst: INCR, awaddr: 32'h4000, awlen: 8'd4, awburst: INCR});
    atx_rdy = 1'b0;
    chn_req_vld = 4'b0010;
    tick();
    sched_en = 1'b0;
    chn_req_vld = 4'hF;
    #1;
    checks++;
    if (chn_req_rdy !== 4'b0000) begin
      errors++; $display("FAIL sched_off_rdy: got %b expected 0000", chn_req_rdy);
    end
    tick();
    checks++;
    if ({atx_vld, atx_chn_id, atx_araddr} !== {1'b1, 2'd1, 32'h3000}) begin
      errors++; $display("FAIL sched_off_hold: got vld=%b chn=%0d araddr=%h expected 1 1 3000", atx_vld, atx_chn_id, atx_araddr);
    end
    atx_rdy = 1'b1;
    #1;
    checks++;
    if (chn_req_rdy !== 4'b0000) begin
      errors++; $display("FAIL sched_off_free: got %b expected 0000", chn_req_rdy);
    end
    tick();
    checks++;
    if (atx_vld !== 1'b0) begin
      errors++; $display("FAIL sched_off_drain: got vld=%b expected 0", atx_vld);
    end
    chn_req_vld = '0;
    atx_done = 4'b0010;
    tick();
    atx_done = '0;
    checks++;
    if (chn_cpl_vld !== 4'b0010) begin
      errors++; $display("FAIL sched_off_cpl: got %b expected 0010", chn_cpl_vld);
    end
    sched_en = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_desc(0, '{araddr: 32'h5000, arlen: 8'd9, arburst: INCR, awaddr: 32'h6000, awlen: 8'd9, awburst: INCR});
    chn_req_vld = 4'b0001;
    tick();
    checks++;
    if ({atx_vld, chn_busy} !== {1'b1, 4'b0001}) begin
      errors++; $display("FAIL arst_pre: got vld=%b busy=%b expected 1 0001", atx_vld, chn_busy);
    end
    #2;
    rst_n = 1'b0;
    atx_done = 4'b0001;
    #1;
    checks++;
    if ({atx_vld, atx_araddr, atx_arid, chn_busy, chn_req_rdy, chn_cpl_vld, chn_cpl_err} !== '0) begin
      errors++;
      $display("FAIL arst_async: got vld=%b araddr=%h busy=%b rdy=%b cpl=%b expected all 0",
               atx_vld, atx_araddr, chn_busy, chn_req_rdy, chn_cpl_vld);
    end
    tick();
    checks++;
    if ({chn_cpl_vld, atx_id} !== {4'b0000, 5'd3, 5'd2, 5'd1, 5'd0}) begin
      errors++; $display("FAIL arst_held: got cpl=%b atx_id=%h expected 0000 %h", chn_cpl_vld, atx_id, {5'd3, 5'd2, 5'd1, 5'd0});
    end
    chn_req_vld = '0;
    atx_done = '0;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({atx_vld, chn_busy, chn_cpl_vld} !== '0) begin
      errors++; $display("FAIL arst_after: got vld=%b busy=%b cpl=%b expected 0", atx_vld, chn_busy, chn_cpl_vld);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_ostd_limit();
    test_errors();
    test_multi_done();
    test_sched_en();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
